// File: rtl/multicycle_control.sv
// Main control FSM for a multi-cycle RV32I datapath (R/I ALU, lw, sw, beq).
// Shared memory port with ready handshake; watchdog and illegal-opcode trap into sticky FAULT.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] Opcode,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic [1:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemtoReg,
   output logic       retire,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [3:0] state
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_MEM_ADDR  = 4'd3;
   localparam logic [3:0] S_MEM_READ  = 4'd4;
   localparam logic [3:0] S_MEM_WB    = 4'd5;
   localparam logic [3:0] S_MEM_WRITE = 4'd6;
   localparam logic [3:0] S_EXEC_R    = 4'd7;
   localparam logic [3:0] S_EXEC_I    = 4'd8;
   localparam logic [3:0] S_ALU_WB    = 4'd9;
   localparam logic [3:0] S_BRANCH    = 4'd10;
   localparam logic [3:0] S_FAULT     = 4'd11;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_ILL  = 2'b01;
   localparam logic [1:0] FC_TMO  = 2'b10;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       r_state;
   logic [3:0]       w_next_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [1:0]       r_fault_code;
   logic [1:0]       w_new_code;
   logic             w_wait_state;
   logic             w_timeout;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
   // ready on the last allowed cycle still wins over the watchdog
   assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == TMO_LAST);

   // next-state and fault-cause selection
   always_comb begin
      w_next_state = r_state;
      w_new_code   = FC_NONE;
      case (r_state)
         S_IDLE:      w_next_state = S_FETCH;
         S_FETCH: begin
            if (mem_ready) begin
               w_next_state = S_DECODE;
            end else if (w_timeout) begin
               w_next_state = S_FAULT;
               w_new_code   = FC_TMO;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            case (Opcode)
               OP_R:         w_next_state = S_EXEC_R;
               OP_I:         w_next_state = S_EXEC_I;
               OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
               OP_BR:        w_next_state = S_BRANCH;
               default: begin
                  w_next_state = S_FAULT;
                  w_new_code   = FC_ILL;
               end
            endcase
         end
         S_MEM_ADDR: begin
            if (Opcode == OP_LW) begin
               w_next_state = S_MEM_READ;
            end else begin
               w_next_state = S_MEM_WRITE;
            end
         end
         S_MEM_READ: begin
            if (mem_ready) begin
               w_next_state = S_MEM_WB;
            end else if (w_timeout) begin
               w_next_state = S_FAULT;
               w_new_code   = FC_TMO;
            end else begin
               w_next_state = S_MEM_READ;
            end
         end
         S_MEM_WB:    w_next_state = S_FETCH;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               w_next_state = S_FETCH;
            end else if (w_timeout) begin
               w_next_state = S_FAULT;
               w_new_code   = FC_TMO;
            end else begin
               w_next_state = S_MEM_WRITE;
            end
         end
         S_EXEC_R, S_EXEC_I: w_next_state = S_ALU_WB;
         S_ALU_WB, S_BRANCH: w_next_state = S_FETCH;
         S_FAULT:     w_next_state = S_FAULT;
         default: begin
            w_next_state = S_FAULT;
            w_new_code   = FC_ILL;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // wait counter: clears on every state change, counts not-ready cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= {CNT_W{1'b0}};
      end else if (w_next_state != r_state) begin
         r_wait_cnt <= {CNT_W{1'b0}};
      end else if (w_wait_state && !mem_ready) begin
         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
         r_wait_cnt <= r_wait_cnt;
      end
   end

   // first fault cause is kept until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_code <= FC_NONE;
      end else if ((r_fault_code == FC_NONE) && (w_new_code != FC_NONE)) begin
         r_fault_code <= w_new_code;
      end else begin
         r_fault_code <= r_fault_code;
      end
   end

   // per-state control outputs, with Mealy terms in FETCH, MEM_WRITE and BRANCH
   always_comb begin
      ALUOp    = 2'b00;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      retire   = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE:   ALUSrcB = 2'b10;
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            retire   = mem_ready;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b10;
         end
         S_ALU_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 1'b1;
            PCWrite = Zero;
            retire  = 1'b1;
         end
         default: ALUOp = 2'b00;
      endcase
   end

   assign fault      = (r_state == S_FAULT);
   assign fault_code = r_fault_code;
   assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and output-vector checks.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [6:0] Opcode;
   logic       Zero;
   logic       mem_ready;
   logic [1:0] ALUOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
   logic       RegWrite, MemtoReg, retire, fault;
   logic [1:0] fault_code;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   // vector order: ALUOp, SrcA, SrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, MemtoReg, retire, fault, fault_code
   logic [16:0] w_vec;
   assign w_vec = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                   PCSrc, RegWrite, MemtoReg, retire, fault, fault_code};

   localparam logic [16:0] V_ZERO      = 17'b00_0_00_0_0_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_FETCH     = 17'b00_0_01_0_1_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_FETCH_RDY = 17'b00_0_01_0_1_0_1_1_0_0_0_0_0_00;
   localparam logic [16:0] V_DECODE    = 17'b00_0_10_0_0_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_MEMADDR   = 17'b00_1_10_0_0_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_MEMREAD   = 17'b00_0_00_1_1_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_MEMWB     = 17'b00_0_00_0_0_0_0_0_0_1_1_1_0_00;
   localparam logic [16:0] V_MEMWR     = 17'b00_0_00_1_0_1_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_MEMWR_RDY = 17'b00_0_00_1_0_1_0_0_0_0_0_1_0_00;
   localparam logic [16:0] V_EXECR     = 17'b10_1_00_0_0_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_EXECI     = 17'b10_1_10_0_0_0_0_0_0_0_0_0_0_00;
   localparam logic [16:0] V_ALUWB     = 17'b00_0_00_0_0_0_0_0_0_1_0_1_0_00;
   localparam logic [16:0] V_BR_Z1     = 17'b01_1_00_0_0_0_0_1_1_0_0_1_0_00;
   localparam logic [16:0] V_BR_Z0     = 17'b01_1_00_0_0_0_0_0_1_0_0_1_0_00;
   localparam logic [16:0] V_FLT_ILL   = 17'b00_0_00_0_0_0_0_0_0_0_0_0_1_01;
   localparam logic [16:0] V_FLT_TMO   = 17'b00_0_00_0_0_0_0_0_0_0_0_0_1_10;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_XX = 7'b1111111;

   multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
      .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .retire(retire),
      .fault(fault), .fault_code(fault_code), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_vec);
      total++;
      assert (state === exp_state) else begin
         bad++;
         $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_state);
      end
      total++;
      assert (w_vec === exp_vec) else begin
         bad++;
         $error("FAIL %s outputs observed=%b expected=%b", tag, w_vec, exp_vec);
      end
   endtask

   // settle, check the current cycle, then move to just after the next rising edge
   task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_vec);
      #1;
      chk(tag, exp_state, exp_vec);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; Opcode = OP_R; Zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 4'd0, V_ZERO);
      rst_n = 1'b1;

      // R-type, memory always ready: 0,1,2,7,9,1
      mem_ready = 1'b1;
      cyc("r_idle", 4'd0, V_ZERO);
      cyc("r_fetch", 4'd1, V_FETCH_RDY);
      cyc("r_decode", 4'd2, V_DECODE);
      cyc("r_exec", 4'd7, V_EXECR);
      cyc("r_wb", 4'd9, V_ALUWB);

      // lw with 3 wait cycles in MEM_READ
      Opcode = OP_LW;
      cyc("lw_fetch", 4'd1, V_FETCH_RDY);
      cyc("lw_decode", 4'd2, V_DECODE);
      cyc("lw_addr", 4'd3, V_MEMADDR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lw_wait", 4'd4, V_MEMREAD);
      mem_ready = 1'b1;
      cyc("lw_read", 4'd4, V_MEMREAD);
      cyc("lw_wb", 4'd5, V_MEMWB);

      // I-type
      Opcode = OP_I;
      cyc("i_fetch", 4'd1, V_FETCH_RDY);
      cyc("i_decode", 4'd2, V_DECODE);
      cyc("i_exec", 4'd8, V_EXECI);
      cyc("i_wb", 4'd9, V_ALUWB);

      // sw with immediate ready
      Opcode = OP_SW;
      cyc("sw_fetch", 4'd1, V_FETCH_RDY);
      cyc("sw_decode", 4'd2, V_DECODE);
      cyc("sw_addr", 4'd3, V_MEMADDR);
      cyc("sw_write", 4'd6, V_MEMWR_RDY);

      // beq taken then not taken
      Opcode = OP_BR; Zero = 1'b1;
      cyc("beq1_fetch", 4'd1, V_FETCH_RDY);
      cyc("beq1_decode", 4'd2, V_DECODE);
      cyc("beq1_branch", 4'd10, V_BR_Z1);
      Zero = 1'b0;
      cyc("beq0_fetch", 4'd1, V_FETCH_RDY);
      cyc("beq0_decode", 4'd2, V_DECODE);
      cyc("beq0_branch", 4'd10, V_BR_Z0);

      // ready arrives on the 15th wait cycle: no fault
      Opcode = OP_R; mem_ready = 1'b0;
      for (int i = 0; i < 14; i++) cyc("nearmiss_wait", 4'd1, V_FETCH);
      mem_ready = 1'b1;
      cyc("nearmiss_fetch", 4'd1, V_FETCH_RDY);
      cyc("nearmiss_decode", 4'd2, V_DECODE);
      cyc("nearmiss_exec", 4'd7, V_EXECR);
      cyc("nearmiss_wb", 4'd9, V_ALUWB);

      // sw stalled in MEM_WRITE, then asynchronous reset mid-cycle
      Opcode = OP_SW;
      cyc("swr_fetch", 4'd1, V_FETCH_RDY);
      cyc("swr_decode", 4'd2, V_DECODE);
      cyc("swr_addr", 4'd3, V_MEMADDR);
      mem_ready = 1'b0;
      cyc("swr_write", 4'd6, V_MEMWR);
      #2;
      chk("swr_pre_reset", 4'd6, V_MEMWR);
      rst_n = 1'b0;
      #1;
      chk("swr_async_reset", 4'd0, V_ZERO);
      @(posedge clk);
      #1;
      chk("swr_hold_reset", 4'd0, V_ZERO);
      rst_n = 1'b1;
      mem_ready = 1'b1; Opcode = OP_XX;
      cyc("swr_idle", 4'd0, V_ZERO);
      cyc("swr_resume_fetch", 4'd1, V_FETCH_RDY);

      // illegal opcode: sticky fault, outputs quiet whatever the inputs do
      cyc("ill_decode", 4'd2, V_DECODE);
      for (int i = 0; i < 22; i++) begin
         mem_ready = i[0];
         Zero      = i[1];
         Opcode    = (i % 3 == 0) ? OP_LW : OP_XX;
         cyc("ill_fault", 4'd11, V_FLT_ILL);
      end

      // memory timeout in FETCH
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("tmo_reset", 4'd0, V_ZERO);
      rst_n = 1'b1; mem_ready = 1'b0; Opcode = OP_R;
      cyc("tmo_idle", 4'd0, V_ZERO);
      for (int i = 0; i < 15; i++) cyc("tmo_wait", 4'd1, V_FETCH);
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc("tmo_fault", 4'd11, V_FLT_TMO);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multi-cycle RV32I datapath (subset: R-type ALU, I-type ALU, lw, sw, beq).
- Drives ALUOp into the ALU control decoder, along with the operand-mux selects, the register and PC write strobes, and the memory strobes.
- Instruction and data memory share one port with a ready handshake.
- A timeout watchdog and an illegal-opcode trap put the core into a sticky FAULT state.

Parameters:
- MEM_TIMEOUT, 15, max consecutive cycles waiting for mem_ready before fault (must be ≥1).
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  7  instruction[6:0] from IR; valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepts write / returns read data this cycle.
- ALUOp  out  2  00 add, 01 sub, 10 use funct.
- ALUSrcA  out  1  0 = PC, 1 = rs1 register.
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- RegWrite  out  1  register file write.
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- retire  out  1  one-cycle pulse when an instruction completes.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- States and encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6.
  - EXEC_R = 7, EXEC_I = 8, ALU_WB = 9, BRANCH = 10, FAULT = 11.
  - Encodings 12–15 are unreachable and go to FAULT with code 01.
- Reset (rst_n low, asynchronous):
  - state = IDLE; wait counter = 0; fault_code = 00.
  - All outputs 0, including ALUOp = 00 and ALUSrcB = 00.
- Outputs not listed for a state below are 0.
- IDLE: all outputs 0; go to FETCH next cycle unconditionally.
- FETCH:
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 0.
  - IRWrite = PCWrite = mem_ready (Mealy, same cycle).
  - Next: DECODE when mem_ready = 1; otherwise stay.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut).
  - Next by Opcode:
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 0000011 or 0100011 → MEM_ADDR.
    - 1100011 → BRANCH.
    - anything else → FAULT with code 01.
- MEM_ADDR:
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - Next: MEM_READ if Opcode = 0000011, otherwise MEM_WRITE.
- MEM_READ: MemRead = 1, IorD = 1; go to MEM_WB on mem_ready.
- MEM_WB: RegWrite = 1, MemtoReg = 1, retire = 1; go to FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1; on mem_ready, retire = 1 (same cycle) and go to FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; go to ALU_WB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10; go to ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0, retire = 1; go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 1, retire = 1.
  - PCWrite = Zero (Mealy).
  - Go to FETCH.
- Latency per instruction, with mem_ready high on its first sampled cycle:
  - R/I-type: 4 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds 1.
- Wait counter (active in FETCH, MEM_READ, MEM_WRITE only):
  - Clears on entry to any state.
  - Increments on each cycle in a wait state with mem_ready = 0.
  - If mem_ready = 0 and counter = MEM_TIMEOUT−1, go to FAULT with code 10. The fault is therefore raised on the MEM_TIMEOUT-th consecutive not-ready cycle.
  - mem_ready = 1 on that same cycle wins: normal transition, no fault.
- FAULT:
  - fault = 1 and fault_code held; all strobes 0.
  - Sticky; only rst_n exits.
  - The first fault code latched is never overwritten.
- Reset mid-operation: any state returns immediately to IDLE with outputs 0. No partial write strobe may be generated after rst_n falls.
- Strobes never overlap: MemRead and MemWrite are never 1 together, and RegWrite is never 1 with MemRead.

Test Plan:
- Reset, then Opcode = 0110011 and mem_ready = 1 constantly → state sequence 0,1,2,7,9,1. RegWrite = 1 only in state 9. retire pulses once at cycle 5 after reset release. ALUOp = 10 in EXEC_R.
- lw (0000011) with mem_ready low for 3 cycles in MEM_READ → MEM_READ lasts 4 cycles with MemRead = IorD = 1. MEM_WB then has RegWrite = MemtoReg = 1. Total 8 cycles FETCH→FETCH.
- beq (1100011), Zero = 1 then repeated with Zero = 0 → in BRANCH, PCWrite = 1 with PCSrc = 1 and ALUOp = 01 for the first case; PCWrite = 0 for the second. Both return to FETCH and both pulse retire.
- Opcode = 1111111 in DECODE → FAULT, fault = 1, fault_code = 01. Outputs stay 0 for 20+ cycles regardless of mem_ready.
- mem_ready held 0 in FETCH with MEM_TIMEOUT = 15 → FAULT entered after the 15th wait cycle, fault_code = 10. A repeat with mem_ready rising on the 15th cycle must reach DECODE with no fault.
- sw in MEM_WRITE with mem_ready = 0, rst_n pulsed low mid-cycle → outputs 0 asynchronously and state = IDLE. Normal fetch resumes 1 cycle after release.
